control_unit: RTL
=================

# control_unit

Multi-cycle sequencer for the 32-bit cs147sec05 processor. Steps every instruction through five one-cycle states, decodes INSTRUCTION, and drives the 32-bit CTRL word that selects every datapath mux, register load and ALU operation. Also drives the memory READ/WRITE strobes. It sits between the datapath, which supplies INSTRUCTION and ZERO, and the memory model.

## Interface
Parameters:
- `CTRL_W`, 32: control word width; constants come from the shared definitions file.

Ports:
- `CLK` in 1: single clock; all state changes occur on the rising edge.
- `RST` in 1: reset, synchronous, active-low.
- `INSTRUCTION` in 32: current IR contents. Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0], addr[25:0].
- `ZERO` in 1: ALU zero flag (combinational from the datapath).
- `CTRL` out 32: datapath control word.
- `READ` out 1: memory read strobe.
- `WRITE` out 1: memory write strobe.

## Operation
CTRL bit map:
- 0 pc_load; 1 pc_sel_1 (0=R1, 1=PC+1); 2 pc_sel_2 (1=branch target); 3 pc_sel_3 (0=jump addr).
- 4 ir_load; 7 r1_sel_1 (0=R0, 1=rs); 8 reg_read; 9 reg_write.
- 10 wa_sel_1 (0=rd, 1=rt); 11 wa_sel_2 (0=R0, 1=R31); 12 wa_sel_3 (1=wa_sel_1 path).
- 13 wd_sel_1 (1=mem data); 14 wd_sel_2 (1=lui imm); 15 wd_sel_3 (0=PC+1).
- 16 sp_load; 17 op1_sel_1 (1=SP); 18 op2_sel_1 (0=const 1, 1=shamt); 19 op2_sel_2 (1=sign-ext imm); 20 op2_sel_3 (1=op2_sel_1 path); 21 op2_sel_4 (1=R2).
- 25:22 alu_oprn: 1 add, 2 sub, 3 mul, 4 shr, 5 shl, 6 and, 7 or, 8 nor, 9 slt.
- 26 ma_sel_1 (1=SP); 27 ma_sel_2 (1=PC); 28 md_sel_1 (0=R2, 1=R1).
- Bits 5, 6, 29–31 are always 0.

State machine: FETCH→DECODE→EXE→MEM→WB→FETCH, unconditional, one cycle each.
- FETCH: READ=1, ma_sel_2=1, ir_load=1. Memory returns data within the cycle; IR captures it on the edge that leaves FETCH.
- DECODE: reg_read=1. r1_sel_1=0 for push; 1 otherwise.
- EXE: alu_oprn and operand selects per opcode.
  - R-type add(0x20) sub(0x22) mul(0x2c) and(0x24) or(0x25) nor(0x27) slt(0x2a): op2=R2.
  - sll(0x01)/srl(0x02): op2=shamt.
  - addi(0x08) muli(0x1d) slti(0x0a) lw(0x23) sw(0x2b): sign-ext imm.
  - andi(0x0c)/ori(0x0d): zero-ext imm.
  - beq(0x04)/bne(0x05): sub R1−R2.
  - push(0x1b): SP−1.
  - pop(0x1c): SP+1, with sp_load=1 in EXE.
- MEM: ALU operand fields are held from EXE.
  - lw: READ=1, ma_sel_2=0, ma_sel_1=0.
  - sw: WRITE=1, md_sel_1=0.
  - push: WRITE=1, ma_sel_1=1, md_sel_1=1.
  - pop: READ=1, ma_sel_1=1.
  - Other opcodes: no strobe.
- WB: pc_load=1 always. ALU fields are held from EXE so ZERO stays valid. READ is held for lw/pop.
  - Default next PC: pc_sel_3=1, pc_sel_2=0, pc_sel_1=1.
  - beq with ZERO=1, or bne with ZERO=0: pc_sel_2=1.
  - jr (R-type funct 0x08): pc_sel_1=0.
  - jmp(0x02) and jal(0x03): pc_sel_3=0.
  - reg_write=1 for: R-type except jr; addi/muli/andi/ori/slti/lui(0x0f)/lw, with wa=rt (wa_sel_3=1, wa_sel_1=1); jal, with wa=R31 and wd=PC+1; pop, with wa=R0 and wd=mem.
  - push: sp_load=1.
- Undefined opcode or funct: executes as NOP (PC+1 only, no writes).

## Timing
- RST=0 at a rising edge: state←FETCH. While RST=0, CTRL=0, READ=0, WRITE=0 (forced combinationally).
- Reset asserted mid-instruction aborts it. No partial write completes after the reset edge.
- First FETCH is the first cycle with RST=1.
- Latency: exactly 5 cycles per instruction, for every opcode including NOP. No stalls.
- Outputs are Moore-style, decoded from state and INSTRUCTION. The one exception is WB branch selection, which also depends on ZERO.
- READ and WRITE are never high in the same cycle.
- reg_write, pc_load and sp_load are each asserted for exactly one cycle per instruction at most. The exception is pop, which asserts sp_load once in EXE.

## Structure
- Shared definitions file holds:
  - opcode and funct constants;
  - ALU operation codes;
  - CTRL bit-index constants;
  - state encoding (3-bit: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4).
- One sub-module, `ctrl_decode`, is natural: a combinational map from (state, INSTRUCTION, ZERO) to CTRL/READ/WRITE. `control_unit` holds the state register and the reset gating.

## Test plan
- Reset: hold RST=0 for 3 cycles in mid-EXE → CTRL=0, READ=0, WRITE=0 throughout; FETCH with READ=1 and CTRL[27]=1, CTRL[4]=1 on the first cycle after release.
- add r3,r1,r2 (0x00221820) → EXE alu_oprn=1 and CTRL[21]=1; WB CTRL[9]=1, CTRL[12]=1, CTRL[10]=0, CTRL[0]=1.
- beq, with ZERO=1 then ZERO=0 in WB → CTRL[2]=1 then CTRL[2]=0; CTRL[3]=1 in both cases.
- lw (opcode 0x23) → MEM READ=1, CTRL[27:26]=0; WB CTRL[13]=1, CTRL[15]=1, CTRL[9]=1.
- push, then pop:
  - push: MEM WRITE=1, CTRL[26]=1, CTRL[28]=1; WB CTRL[16]=1.
  - pop: EXE CTRL[16]=1 with alu_oprn=1; WB writes R0 from memory data.
- jal 0x000010 → WB CTRL[3]=0, CTRL[11]=1, CTRL[12]=0, CTRL[15]=0. An illegal opcode 0x3f gives WB with only CTRL[0], CTRL[1] and CTRL[3] set.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared encodings for the cs147sec05 control unit: opcodes, functs, ALU codes,
// CTRL bit positions and the sequencer state encoding.
package control_unit_pkg;

  localparam int CTRL_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;
  localparam logic [5:0] OP_MULI  = 6'h1d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_MUL = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_OR  = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;

  localparam int B_PC_LOAD   = 0;
  localparam int B_PC_SEL_1  = 1;
  localparam int B_PC_SEL_2  = 2;
  localparam int B_PC_SEL_3  = 3;
  localparam int B_IR_LOAD   = 4;
  localparam int B_R1_SEL_1  = 7;
  localparam int B_REG_READ  = 8;
  localparam int B_REG_WRITE = 9;
  localparam int B_WA_SEL_1  = 10;
  localparam int B_WA_SEL_2  = 11;
  localparam int B_WA_SEL_3  = 12;
  localparam int B_WD_SEL_1  = 13;
  localparam int B_WD_SEL_2  = 14;
  localparam int B_WD_SEL_3  = 15;
  localparam int B_SP_LOAD   = 16;
  localparam int B_OP1_SEL_1 = 17;
  localparam int B_OP2_SEL_1 = 18;
  localparam int B_OP2_SEL_2 = 19;
  localparam int B_OP2_SEL_3 = 20;
  localparam int B_OP2_SEL_4 = 21;
  localparam int B_ALU_LSB   = 22;
  localparam int B_MA_SEL_1  = 26;
  localparam int B_MA_SEL_2  = 27;
  localparam int B_MD_SEL_1  = 28;

endpackage

// File: rtl/control_unit_ctrl_decode.sv
// Combinational map from (state, instruction, zero) to the datapath control word
// and memory strobes.
module ctrl_decode
  import control_unit_pkg::*;
#(
  parameter int CTRL_W = CTRL_WIDTH
) (
  input  state_t            state,
  input  logic [31:0]       instruction,
  input  logic              zero,
  output logic [CTRL_W-1:0] ctrl,
  output logic              read,
  output logic              write
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] alu_op;
  logic       op1_sp, op2_shamt, op2_imm, op2_s3, op2_r2, r_write;
  logic [CTRL_W-1:0] alu_word;
  logic       unused_fields;

  assign opcode        = instruction[31:26];
  assign funct         = instruction[5:0];
  assign unused_fields = ^instruction[25:6];

  // ALU operation and operand selects; held from EXE through WB.
  always_comb begin
    alu_op    = '0;
    op1_sp    = 1'b0;
    op2_shamt = 1'b0;
    op2_imm   = 1'b0;
    op2_s3    = 1'b0;
    op2_r2    = 1'b0;
    r_write   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin alu_op = ALU_ADD; op2_r2 = 1'b1; r_write = 1'b1; end
          FN_SUB: begin alu_op = ALU_SUB; op2_r2 = 1'b1; r_write = 1'b1; end
          FN_MUL: begin alu_op = ALU_MUL; op2_r2 = 1'b1; r_write = 1'b1; end
          FN_AND: begin alu_op = ALU_AND; op2_r2 = 1'b1; r_write = 1'b1; end
          FN_OR:  begin alu_op = ALU_OR;  op2_r2 = 1'b1; r_write = 1'b1; end
          FN_NOR: begin alu_op = ALU_NOR; op2_r2 = 1'b1; r_write = 1'b1; end
          FN_SLT: begin alu_op = ALU_SLT; op2_r2 = 1'b1; r_write = 1'b1; end
          FN_SLL: begin alu_op = ALU_SHL; op2_shamt = 1'b1; op2_s3 = 1'b1; r_write = 1'b1; end
          FN_SRL: begin alu_op = ALU_SHR; op2_shamt = 1'b1; op2_s3 = 1'b1; r_write = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin alu_op = ALU_ADD; op2_imm = 1'b1; end
      OP_MULI: begin alu_op = ALU_MUL; op2_imm = 1'b1; end
      OP_SLTI: begin alu_op = ALU_SLT; op2_imm = 1'b1; end
      OP_ANDI: alu_op = ALU_AND;
      OP_ORI:  alu_op = ALU_OR;
      OP_BEQ, OP_BNE: begin alu_op = ALU_SUB; op2_r2 = 1'b1; end
      OP_PUSH: begin alu_op = ALU_SUB; op1_sp = 1'b1; op2_s3 = 1'b1; end
      OP_POP:  begin alu_op = ALU_ADD; op1_sp = 1'b1; op2_s3 = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    alu_word                    = '0;
    alu_word[B_ALU_LSB +: 4]    = alu_op;
    alu_word[B_OP1_SEL_1]       = op1_sp;
    alu_word[B_OP2_SEL_1]       = op2_shamt;
    alu_word[B_OP2_SEL_2]       = op2_imm;
    alu_word[B_OP2_SEL_3]       = op2_s3;
    alu_word[B_OP2_SEL_4]       = op2_r2;
  end

  always_comb begin
    ctrl  = '0;
    read  = 1'b0;
    write = 1'b0;
    case (state)
      ST_FETCH: begin
        read             = 1'b1;
        ctrl[B_MA_SEL_2] = 1'b1;
        ctrl[B_IR_LOAD]  = 1'b1;
      end
      ST_DECODE: begin
        ctrl[B_REG_READ] = 1'b1;
        ctrl[B_R1_SEL_1] = (opcode != OP_PUSH);
      end
      ST_EXE: begin
        ctrl = alu_word;
        ctrl[B_SP_LOAD] = (opcode == OP_POP);
      end
      ST_MEM: begin
        ctrl = alu_word;
        case (opcode)
          OP_LW:   read = 1'b1;
          OP_SW:   write = 1'b1;
          OP_PUSH: begin write = 1'b1; ctrl[B_MA_SEL_1] = 1'b1; ctrl[B_MD_SEL_1] = 1'b1; end
          OP_POP:  begin read = 1'b1; ctrl[B_MA_SEL_1] = 1'b1; end
          default: ;
        endcase
      end
      ST_WB: begin
        ctrl = alu_word;
        ctrl[B_PC_LOAD]  = 1'b1;
        ctrl[B_PC_SEL_1] = 1'b1;
        ctrl[B_PC_SEL_3] = 1'b1;
        if (r_write) begin
          ctrl[B_REG_WRITE] = 1'b1;
          ctrl[B_WA_SEL_3]  = 1'b1;
          ctrl[B_WD_SEL_3]  = 1'b1;
        end
        case (opcode)
          OP_RTYPE: if (funct == FN_JR) ctrl[B_PC_SEL_1] = 1'b0;
          OP_BEQ:   ctrl[B_PC_SEL_2] = zero;
          OP_BNE:   ctrl[B_PC_SEL_2] = ~zero;
          OP_JMP:   ctrl[B_PC_SEL_3] = 1'b0;
          OP_JAL: begin
            ctrl[B_PC_SEL_3]  = 1'b0;
            ctrl[B_REG_WRITE] = 1'b1;
            ctrl[B_WA_SEL_2]  = 1'b1;
          end
          OP_ADDI, OP_MULI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI, OP_LW: begin
            ctrl[B_REG_WRITE] = 1'b1;
            ctrl[B_WA_SEL_3]  = 1'b1;
            ctrl[B_WA_SEL_1]  = 1'b1;
            ctrl[B_WD_SEL_3]  = 1'b1;
            ctrl[B_WD_SEL_2]  = (opcode == OP_LUI);
            ctrl[B_WD_SEL_1]  = (opcode == OP_LW);
            read              = (opcode == OP_LW);
          end
          OP_POP: begin
            // Memory data still on the bus: keep the SP address and read strobe.
            read              = 1'b1;
            ctrl[B_MA_SEL_1]  = 1'b1;
            ctrl[B_REG_WRITE] = 1'b1;
            ctrl[B_WD_SEL_3]  = 1'b1;
            ctrl[B_WD_SEL_1]  = 1'b1;
          end
          OP_PUSH: ctrl[B_SP_LOAD] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Five-state instruction sequencer; outputs are forced to zero while reset is held.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int CTRL_W = CTRL_WIDTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       INSTRUCTION,
  input  logic              ZERO,
  output logic [CTRL_W-1:0] CTRL,
  output logic              READ,
  output logic              WRITE
);

  state_t            state_reg, state_next;
  logic [CTRL_W-1:0] ctrl_raw;
  logic              read_raw, write_raw;

  always_ff @(posedge CLK) begin
    if (!RST) state_reg <= ST_FETCH;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = ST_FETCH;
    case (state_reg)
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXE;
      ST_EXE:    state_next = ST_MEM;
      ST_MEM:    state_next = ST_WB;
      default:   state_next = ST_FETCH;
    endcase
  end

  ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
    .state       (state_reg),
    .instruction (INSTRUCTION),
    .zero        (ZERO),
    .ctrl        (ctrl_raw),
    .read        (read_raw),
    .write       (write_raw)
  );

  // Gating here means an aborted instruction cannot strobe memory or registers.
  assign CTRL  = RST ? ctrl_raw  : '0;
  assign READ  = RST ? read_raw  : 1'b0;
  assign WRITE = RST ? write_raw : 1'b0;

endmodule
